// File: rtl/grid_pkg.sv
// Shared constants and elaboration-time helpers for the grid renderer.
package grid_pkg;

   localparam int unsigned TW = 11;

   localparam logic [11:0] BG_RGB_DEF   = 12'h888;
   localparam logic [11:0] LINE_RGB_DEF = 12'h000;
   localparam logic [11:0] SEL_RGB_DEF  = 12'hfc0;

   localparam int unsigned GRID_N_DEF = 3;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned IDX_W = idx_width(GRID_N_DEF);

   // Evaluated only at elaboration; no divider reaches the netlist.
   function automatic int unsigned cell_size(input int unsigned active, input int unsigned n);
      return active / n;
   endfunction

endpackage

// File: rtl/grid_axis_tracker.sv
// Offset/index counter for one screen axis; the index saturates at N-1 so the
// remainder pixels fall into the last cell.
module grid_axis_tracker
   import grid_pkg::*;
#(
   parameter int unsigned SIZE = 341,
   parameter int unsigned N = 3,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          restart_i,
   input  logic          advance_i,
   output logic [TW-1:0] off_o,
   output logic [IW-1:0] idx_o
);

   localparam logic [TW-1:0] OFF_LAST = TW'(SIZE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   logic [TW-1:0] off_q, off_d;
   logic [IW-1:0] idx_q, idx_d;

   always_comb begin
      off_d = off_q;
      idx_d = idx_q;
      if (restart_i) begin
         off_d = '0;
         idx_d = '0;
      end else if (advance_i) begin
         if (off_q == OFF_LAST && idx_q < IDX_LAST) begin
            off_d = '0;
            idx_d = idx_q + IW'(1);
         end else if (off_q != '1) begin
            off_d = off_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         off_q <= '0;
         idx_q <= '0;
      end else begin
         off_q <= off_d;
         idx_q <= idx_d;
      end
   end

   assign off_o = off_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/draw_grid.sv
// Two-stage grid background renderer with selected-cell highlight.
// Define DRAW_GRID_BORDER_EN to add an outer LINE_W frame around the active area.
module draw_grid
   import grid_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned GRID_N = 3,
   parameter int unsigned LINE_W = 5,
   parameter logic [11:0] BG_RGB = BG_RGB_DEF,
   parameter logic [11:0] LINE_RGB = LINE_RGB_DEF,
   parameter logic [11:0] SEL_RGB = SEL_RGB_DEF,
   localparam int unsigned IW = idx_width(GRID_N)
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic [10:0]   hcount_in,
   input  logic          hsync_in,
   input  logic          hblnk_in,
   input  logic [10:0]   vcount_in,
   input  logic          vsync_in,
   input  logic          vblnk_in,
   input  logic [IW-1:0] sel_col,
   input  logic [IW-1:0] sel_row,
   input  logic          sel_valid,
   output logic [10:0]   hcount_out,
   output logic          hsync_out,
   output logic          hblnk_out,
   output logic [10:0]   vcount_out,
   output logic          vsync_out,
   output logic          vblnk_out,
   output logic [11:0]   rgb_out,
   output logic [IW-1:0] cell_col_out,
   output logic [IW-1:0] cell_row_out,
   output logic          on_line_out
);

   localparam int unsigned CELL_W = cell_size(H_ACTIVE, GRID_N);
   localparam int unsigned CELL_H = cell_size(V_ACTIVE, GRID_N);
   localparam logic [TW-1:0] LINE_W_C = TW'(LINE_W);
`ifdef DRAW_GRID_BORDER_EN
   localparam logic [TW-1:0] H_EDGE = TW'(H_ACTIVE - LINE_W);
   localparam logic [TW-1:0] V_EDGE = TW'(V_ACTIVE - LINE_W);
   localparam logic [TW-1:0] H_END  = TW'(H_ACTIVE);
   localparam logic [TW-1:0] V_END  = TW'(V_ACTIVE);
`endif

   // Stage 1: timing, sync flag, selection shadow; trackers hold this pixel's position.
   logic [10:0]   hcount_q, vcount_q;
   logic          hsync_q, hblnk_q, vsync_q, vblnk_q;
   logic          synced_q;
   logic [IW-1:0] sel_col_q, sel_row_q;
   logic          sel_valid_q;
   logic [TW-1:0] h_off, v_off;
   logic [IW-1:0] h_idx, v_idx;

   // Stage 2 next-state
   logic [11:0]   rgb_d;
   logic [IW-1:0] col_d, row_d;
   logic          on_line_d, selected;

   grid_axis_tracker #(.SIZE(CELL_W), .N(GRID_N)) u_h_track (
      .clk_i    (pclk),
      .rst_i    (rst),
      .restart_i(hcount_in == 11'd0),
      .advance_i(1'b1),
      .off_o    (h_off),
      .idx_o    (h_idx)
   );

   grid_axis_tracker #(.SIZE(CELL_H), .N(GRID_N)) u_v_track (
      .clk_i    (pclk),
      .rst_i    (rst),
      .restart_i(vcount_in == 11'd0),
      .advance_i(hcount_in == 11'd0),
      .off_o    (v_off),
      .idx_o    (v_idx)
   );

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_q    <= '0;
         vcount_q    <= '0;
         hsync_q     <= 1'b0;
         hblnk_q     <= 1'b0;
         vsync_q     <= 1'b0;
         vblnk_q     <= 1'b0;
         synced_q    <= 1'b0;
         sel_col_q   <= '0;
         sel_row_q   <= '0;
         sel_valid_q <= 1'b0;
      end else begin
         hcount_q <= hcount_in;
         vcount_q <= vcount_in;
         hsync_q  <= hsync_in;
         hblnk_q  <= hblnk_in;
         vsync_q  <= vsync_in;
         vblnk_q  <= vblnk_in;
         if (hcount_in == 11'd0 && vcount_in == 11'd0) synced_q <= 1'b1;
         if (vsync_in && !vsync_q) begin
            sel_col_q   <= sel_col;
            sel_row_q   <= sel_row;
            sel_valid_q <= sel_valid;
         end
      end
   end

   // Indices never exceed GRID_N-1, so an out-of-range shadow index never matches.
   always_comb begin
      on_line_d = (h_idx != '0 && h_off < LINE_W_C) || (v_idx != '0 && v_off < LINE_W_C);
`ifdef DRAW_GRID_BORDER_EN
      on_line_d = on_line_d
                  || (h_idx == '0 && h_off < LINE_W_C)
                  || (hcount_q >= H_EDGE && hcount_q < H_END)
                  || (v_idx == '0 && v_off < LINE_W_C)
                  || (vcount_q >= V_EDGE && vcount_q < V_END);
`endif
      selected = sel_valid_q && sel_col_q == h_idx && sel_row_q == v_idx;
      rgb_d = '0;
      col_d = '0;
      row_d = '0;
      if (synced_q) begin
         col_d = h_idx;
         row_d = v_idx;
         if (hblnk_q || vblnk_q) rgb_d = '0;
         else if (on_line_d)     rgb_d = LINE_RGB;
         else if (selected)      rgb_d = SEL_RGB;
         else                    rgb_d = BG_RGB;
      end else begin
         on_line_d = 1'b0;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_out   <= '0;
         vcount_out   <= '0;
         hsync_out    <= 1'b0;
         hblnk_out    <= 1'b0;
         vsync_out    <= 1'b0;
         vblnk_out    <= 1'b0;
         rgb_out      <= '0;
         cell_col_out <= '0;
         cell_row_out <= '0;
         on_line_out  <= 1'b0;
      end else begin
         hcount_out   <= hcount_q;
         vcount_out   <= vcount_q;
         hsync_out    <= hsync_q;
         hblnk_out    <= hblnk_q;
         vsync_out    <= vsync_q;
         vblnk_out    <= vblnk_q;
         rgb_out      <= rgb_d;
         cell_col_out <= col_d;
         cell_row_out <= row_d;
         on_line_out  <= on_line_d;
      end
   end

endmodule
